// File: rtl/alu_arb_pkg.sv
// Shared types, ALU op codes and the legal-op helper for alu_share_arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_ORR  = 4'b0100;
    localparam logic [3:0] OP_EOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_CBNZ = 4'b0001;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR,
            OP_NOR, OP_NAND, OP_MOV, OP_CBZ, OP_CBNZ: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid index at or after ptr_i, wrapping.
module rr_grant #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] j;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (valid_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = j;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters.
// Optional macro ALU_ARB_ILLEGAL_OP_EN adds resp_err and short-circuits
// illegal op codes straight to the response phase.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ-1:0]        req_src,
    input  logic [NUM_REQ*DATA_W-1:0] req_rd1,
    input  logic [NUM_REQ*DATA_W-1:0] req_sext,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_zero,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output logic                      resp_err,
`endif
    output logic [OP_W-1:0]           alu_ctrl,
    output logic                      alu_src,
    output logic [DATA_W-1:0]         alu_rd1,
    output logic [DATA_W-1:0]         alu_sext,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]      ctrl_q, ctrl_d;
    logic                 src_q, src_d;
    logic [DATA_W-1:0]    rd1_q, rd1_d;
    logic [DATA_W-1:0]    sext_q, sext_d;
    logic [DATA_W-1:0]    res_q, res_d;
    logic                 zero_q, zero_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic                 err_q, err_d;
`endif

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [OP_W-1:0]      sel_op;
    logic                 sel_illegal;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign sel_op = req_op[pick_idx*OP_W +: OP_W];

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign sel_illegal = !is_legal_op(4'(sel_op));
`else
    assign sel_illegal = 1'b0;
`endif

    // Next-state: IDLE picks a winner, ISSUE samples the ALU, RESP waits for the owner.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        ctrl_d   = ctrl_q;
        src_d    = src_q;
        rd1_d    = rd1_q;
        sext_d   = sext_q;
        res_d    = res_q;
        zero_d   = zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d = pick_idx;
                    if (sel_illegal) begin
                        // ALU inputs are left untouched; the response is a fixed error.
                        state_d = RESP;
                        res_d   = '0;
                        zero_d  = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = ISSUE;
                        ctrl_d  = sel_op;
                        src_d   = req_src[pick_idx];
                        rd1_d   = req_rd1[pick_idx*DATA_W +: DATA_W];
                        sext_d  = req_sext[pick_idx*DATA_W +: DATA_W];
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
                res_d   = alu_result;
                zero_d  = alu_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                err_d   = 1'b0;
`endif
            end
            RESP: begin
                if (resp_ready[gnt_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            ctrl_q   <= '0;
            src_q    <= 1'b0;
            rd1_q    <= '0;
            sext_q   <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            ctrl_q   <= ctrl_d;
            src_q    <= src_d;
            rd1_q    <= rd1_d;
            sext_q   <= sext_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q    <= err_d;
`endif
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign req_ready   = (state_q == IDLE && rst_n) ? pick_oh : '0;
    assign resp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign resp_result = res_q;
    assign resp_zero   = zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign resp_err    = err_q;
`endif
    assign alu_ctrl    = ctrl_q;
    assign alu_src     = src_q;
    assign alu_rd1     = rd1_q;
    assign alu_sext    = sext_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed steps, then random traffic
// checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam logic [3:0] LEGAL [10] = '{4'h2, 4'hA, 4'h6, 4'h4, 4'h9, 4'h5, 4'hC, 4'hD, 4'h7, 4'h1};
`ifdef ALU_ARB_ILLEGAL_OP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_ready, req_src = '0, resp_valid, resp_ready = '0;
    logic [N*OW-1:0] req_op = '0;
    logic [N*DW-1:0] req_rd1 = '0, req_sext = '0;
    logic [DW-1:0]   resp_result, alu_rd1, alu_sext, alu_result;
    logic            resp_zero, alu_src, alu_zero;
    logic [OW-1:0]   alu_ctrl;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic            resp_err;
`endif

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_src(req_src),
        .req_rd1(req_rd1), .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
`ifdef ALU_ARB_ILLEGAL_OP_EN
        .resp_err(resp_err),
`endif
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .alu_rd1(alu_rd1), .alu_sext(alu_sext),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(logic [3:0] op);
        for (int k = 0; k < 10; k++) if (LEGAL[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Behavioural ALU; {zero, result}. Undefined codes give 0/0.
    function automatic logic [32:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic        z;
        r = '0;
        z = 1'b0;
        case (op)
            4'h2: r = a + b;
            4'hA: r = a - b;
            4'h6: r = a & b;
            4'h4: r = a | b;
            4'h9: r = a ^ b;
            4'h5: r = ~(a | b);
            4'hC: r = ~(a & b);
            4'hD, 4'h7, 4'h1: r = b;
            default: r = '0;
        endcase
        if (op == 4'h1) z = (b != 0);
        else if (is_legal(op)) z = (r == 0);
        return {z, r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_fn(alu_ctrl, alu_rd1, alu_src ? alu_sext : alu_rd1);

    int checks = 0, errors = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one outstanding transaction, timed from its acceptance cycle.
    int          cyc = 0, ptr = 0, last_g = -1;
    bit          pend = 0, p_ill = 0;
    int          p_idx, p_t, p_lat;
    logic [3:0]  p_op;
    logic [31:0] p_rd1, p_sext;
    logic        p_src;
    logic [3:0]  e_ctrl = '0;
    logic        e_src = 1'b0, e_zero = 1'b0, e_err = 1'b0;
    logic [31:0] e_rd1 = '0, e_sext = '0, e_res = '0;

    task automatic model_reset();
        pend = 0; ptr = 0; last_g = -1;
        e_ctrl = '0; e_src = 0; e_rd1 = '0; e_sext = '0; e_res = '0; e_zero = 0; e_err = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] e_rdy, e_rv;
        logic [32:0]  r;
        int           g;
        e_rdy = '0; e_rv = '0; g = -1;
        if (pend && cyc > p_t && !p_ill) begin
            e_ctrl = p_op; e_src = p_src; e_rd1 = p_rd1; e_sext = p_sext;
        end
        if (pend && cyc == p_t + p_lat) begin
            if (p_ill) begin
                e_res = '0; e_zero = 0; e_err = 1;
            end else begin
                r = alu_fn(p_op, p_rd1, p_src ? p_sext : p_rd1);
                e_res = r[31:0]; e_zero = r[32]; e_err = 0;
            end
        end
        if (!pend) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
            if (g >= 0) e_rdy[g] = 1'b1;
        end else if (cyc >= p_t + p_lat) begin
            e_rv[p_idx] = 1'b1;
        end
        chk("req_ready", req_ready, e_rdy);
        chk("resp_valid", resp_valid, e_rv);
        chk("resp_result", resp_result, e_res);
        chk("resp_zero", resp_zero, e_zero);
        chk("alu_ctrl", alu_ctrl, e_ctrl);
        chk("alu_src", alu_src, e_src);
        chk("alu_rd1", alu_rd1, e_rd1);
        chk("alu_sext", alu_sext, e_sext);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("resp_err", resp_err, e_err);
`endif
        if (e_rv != '0 && resp_ready[p_idx]) begin
            pend = 0;
            ptr  = (p_idx + 1) % N;
        end
        last_g = g;
        if (g >= 0) begin
            pend = 1; p_idx = g; p_t = cyc;
            p_op = req_op[g*OW +: OW]; p_src = req_src[g];
            p_rd1 = req_rd1[g*DW +: DW]; p_sext = req_sext[g*DW +: DW];
            p_ill = ERR_EN && !is_legal(p_op);
            p_lat = p_ill ? 1 : 2;
        end
        cyc++;
    endtask

    task automatic cyc_chk(); @(negedge clk); model_step(); endtask
    task automatic adv(); @(posedge clk); #1; endtask
    task automatic run(int n); repeat (n) begin cyc_chk(); adv(); end endtask

    task automatic set_req(int i, logic v, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic s);
        req_valid[i] = v;
        req_op[i*OW +: OW] = op;
        req_rd1[i*DW +: DW] = a;
        req_sext[i*DW +: DW] = b;
        req_src[i] = s;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_rdy"}, req_ready, 0);
        chk({tag, "_rv"}, resp_valid, 0);
        chk({tag, "_res"}, resp_result, 0);
        chk({tag, "_zero"}, resp_zero, 0);
        chk({tag, "_ctrl"}, alu_ctrl, 0);
        chk({tag, "_src"}, alu_src, 0);
        chk({tag, "_rd1"}, alu_rd1, 0);
        chk({tag, "_sext"}, alu_sext, 0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk({tag, "_err"}, resp_err, 0);
`endif
    endtask

    // Called a little after a rising edge; asserts reset mid-cycle.
    task automatic async_reset(string tag);
        #2 rst_n = 1'b0;
        #1 chk_all_zero(tag);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int oh2i(logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gl[$];
        logic [31:0] a, b;

        // Reset state, then quiet idle.
        #3 chk_all_zero("reset");
        model_reset();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) begin cyc_chk(); chk_all_zero("idle"); adv(); end

        // Single request: ADD 5 + 7 via ALUSrc.
        resp_ready = '1;
        set_req(0, 1, 4'b0010, 5, 7, 1);
        cyc_chk(); chk("single_rdy", req_ready, 3'b001); adv();
        req_valid[0] = 0;
        cyc_chk();
        chk("single_ctrl", alu_ctrl, 4'b0010); chk("single_src", alu_src, 1);
        chk("single_rd1", alu_rd1, 5); chk("single_sext", alu_sext, 7);
        adv();
        cyc_chk();
        chk("single_rv", resp_valid, 3'b001); chk("single_res", resp_result, 12);
        chk("single_zero", resp_zero, 0);
        adv();
        async_reset("idle_rst");

        // Contention from rr_ptr=0: grants must alternate 0,1,0,1.
        set_req(0, 1, 4'b0010, 5, 7, 1);
        set_req(1, 1, 4'b1010, 9, 9, 1);
        repeat (12) begin
            cyc_chk();
            if (req_ready != '0) gl.push_back(oh2i(req_ready));
            if (resp_valid == 3'b010) chk("cont_res1", resp_result, 0);
            adv();
        end
        chk("cont_ngrants", gl.size(), 4);
        for (int i = 0; i < 4; i++) chk("cont_order", (i < gl.size()) ? gl[i] : -1, i % 2);
        req_valid = '0;
        run(3);

        // Backpressure on requester 0 while requester 1 waits.
        resp_ready = '0;
        set_req(0, 1, 4'b0010, 1, 2, 1);
        cyc_chk(); chk("bp_gnt0", req_ready, 3'b001); adv();
        req_valid[0] = 0;
        set_req(1, 1, 4'b1001, 3, 5, 1);
        cyc_chk(); chk("bp_issue_nogrant", req_ready, 0); adv();
        repeat (5) begin
            cyc_chk();
            chk("bp_hold_rv", resp_valid, 3'b001); chk("bp_hold_res", resp_result, 3);
            chk("bp_hold_nogrant", req_ready, 0);
            adv();
        end
        resp_ready = 3'b001;
        cyc_chk(); chk("bp_release_rv", resp_valid, 3'b001); adv();
        resp_ready = '1;
        cyc_chk(); chk("bp_gnt1", req_ready, 3'b010); adv();
        req_valid[1] = 0;
        run(3);

        // CBZ with zero operand.
        set_req(0, 1, 4'b0111, 1234, 0, 1);
        cyc_chk(); adv();
        req_valid[0] = 0;
        cyc_chk(); adv();
        cyc_chk();
        chk("cbz_rv", resp_valid, 3'b001); chk("cbz_zero", resp_zero, 1); chk("cbz_res", resp_result, 0);
        adv();

        // Reset while the op sits in ISSUE: no response may follow.
        set_req(1, 1, 4'b0010, 100, 200, 1);
        cyc_chk(); chk("rst_gnt", req_ready, 3'b010); adv();
        req_valid[1] = 0;
        async_reset("issue_rst");
        repeat (5) begin cyc_chk(); chk("post_rst_no_resp", resp_valid, 0); adv(); end

`ifdef ALU_ARB_ILLEGAL_OP_EN
        // Illegal code responds one cycle after acceptance with resp_err.
        set_req(0, 1, 4'b1111, 7, 7, 1);
        cyc_chk(); chk("ill_gnt", req_ready, 3'b001); adv();
        req_valid[0] = 0;
        cyc_chk();
        chk("ill_rv", resp_valid, 3'b001); chk("ill_err", resp_err, 1); chk("ill_res", resp_result, 0);
        adv();
        set_req(0, 1, 4'b0010, 1, 1, 1);
        cyc_chk(); adv();
        req_valid[0] = 0;
        cyc_chk(); adv();
        cyc_chk();
        chk("legal_err", resp_err, 0); chk("legal_res", resp_result, 2);
        adv();
`endif

        // Random traffic: requests held until granted, occasional withdrawal.
        repeat (3000) begin
            cyc_chk();
            adv();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    if ($urandom_range(0, 99) < 50) begin
                        a = $urandom;
                        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                        if ($urandom_range(0, 7) == 0) b = '0;
                        set_req(i, 1, ($urandom_range(0, 9) < 8) ? LEGAL[$urandom_range(0, 9)] : 4'($urandom),
                                a, b, 1'($urandom));
                    end else begin
                        req_valid[i] = 0;
                    end
                end else if ($urandom_range(0, 99) < 5) begin
                    req_valid[i] = 0;
                end
            end
            resp_ready = N'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
